reference_sweep: RTL

Read sequencer that sits directly upstream of `reference_buffer` in the CAF datapath. On `start` it issues one full sweep of `buffer_length` reads, beginning at a programmable circular `offset`. It drives the buffer's read-request port, collects the I/Q samples the buffer returns two cycles later, and streams them to the downstream correlator over a valid/ready interface with backpressure. It marks the final sample with `out_last` and pulses `done` when that sample is accepted.

---
 rtl/caf_pkg.sv | 20 ++
 rtl/reference_sweep_if.sv | 26 ++
 rtl/ref_sample_fifo.sv | 52 +++++
 rtl/reference_sweep.sv | 120 ++++++++++++
 4 files changed

// File: rtl/caf_pkg.sv
// Shared types and constants for the CAF reference read path.
package caf_pkg;

   localparam int REF_READ_LATENCY = 2;
   localparam int I_BITS = 12;
   localparam int Q_BITS = 12;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } sweep_state_t;

   typedef struct packed {
      logic                     last;
      logic signed [I_BITS-1:0] i;
      logic signed [Q_BITS-1:0] q;
   } ref_sample_t;

endpackage

// File: rtl/reference_sweep_if.sv
// Downstream sample stream from the sweep to the correlator.
interface reference_sweep_if;
   import caf_pkg::*;

   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;
   logic signed [I_BITS-1:0] out_i;
   logic signed [Q_BITS-1:0] out_q;

   modport master (
      output out_valid,
      output out_i,
      output out_q,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_i,
      input  out_q,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/ref_sample_fifo.sv
// Synchronous FIFO with registered storage and an occupancy count.
module ref_sample_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // a full FIFO still takes a push when the head leaves in the same cycle
   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
endmodule

// File: rtl/reference_sweep.sv
// Issues one circular sweep of reference-buffer reads and streams
// the returned I/Q samples downstream under credit-based flow control.
module reference_sweep
   import caf_pkg::*;
#(
   parameter int BUFFER_LENGTH = 10,
   parameter int INDEX_BITS    = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [INDEX_BITS-1:0]    offset,
   output logic                     busy,
   output logic                     done,
   output logic                     m_axi_rvalid,
   output logic                     m_axi_rready,
   output logic [INDEX_BITS-1:0]    m_axi_raddr,
   input  logic                     s_axi_rready,
   input  logic signed [I_BITS-1:0] ref_i,
   input  logic signed [Q_BITS-1:0] ref_q,
   input  logic                     s_axi_data_rvalid,
   reference_sweep_if.master        dn
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(BUFFER_LENGTH - 1);
   localparam logic [CW:0]           DEPTH_C  = (CW + 1)'(FIFO_DEPTH);

   sweep_state_t          r_state;
   sweep_state_t          w_next;
   logic [INDEX_BITS-1:0] r_addr;
   logic [INDEX_BITS-1:0] r_iss_cnt;
   logic [INDEX_BITS-1:0] r_push_cnt;
   logic [CW-1:0]         r_inflight;
   logic [CW-1:0]         w_count;
   logic                  r_done;
   logic                  w_start_ok;
   logic                  w_room;
   logic                  w_issue;
   logic                  w_accept;
   logic                  w_pop;
   logic                  w_empty;
   ref_sample_t           w_push_data;
   ref_sample_t           w_head;

   assign w_start_ok = start && (offset <= LAST_IDX);
   // credits = depth - fifo_count - inflight; issue only while positive
   assign w_room   = ({1'b0, w_count} + {1'b0, r_inflight}) < DEPTH_C;
   assign w_issue  = (r_state == ISSUE) && s_axi_rready && w_room;
   assign w_accept = s_axi_data_rvalid && (r_inflight != '0);
   assign w_pop    = !w_empty && dn.out_ready;

   assign w_push_data = '{last: (r_push_cnt == LAST_IDX), i: ref_i, q: ref_q};

   ref_sample_fifo #(
      .WIDTH($bits(ref_sample_t)),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_accept),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_start_ok) w_next = ISSUE;
         ISSUE:   if (w_issue && (r_iss_cnt == LAST_IDX)) w_next = DRAIN;
         DRAIN:   if (r_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_iss_cnt  <= '0;
         r_push_cnt <= '0;
         r_inflight <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_next;
         if ((r_state == IDLE) && w_start_ok) begin
            r_addr     <= offset;
            r_iss_cnt  <= '0;
            r_push_cnt <= '0;
         end else begin
            if (w_issue) begin
               r_addr    <= (r_addr == LAST_IDX) ? '0 : r_addr + INDEX_BITS'(1);
               r_iss_cnt <= r_iss_cnt + INDEX_BITS'(1);
            end
            if (w_accept) r_push_cnt <= r_push_cnt + INDEX_BITS'(1);
         end
         unique case ({w_issue, w_accept})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         // done stays high one cycle; DRAIN leaves on it so busy drops with it
         r_done <= (r_state == DRAIN) && w_pop && w_head.last;
      end
   end

   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign m_axi_rvalid = w_issue;
   assign m_axi_rready = rst_n;
   assign m_axi_raddr  = r_addr;

   assign dn.out_valid = !w_empty;
   assign dn.out_i     = w_head.i;
   assign dn.out_q     = w_head.q;
   assign dn.out_last  = w_head.last;
endmodule
